// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: per-frame latched divisor, parity mode and stop length.
// Oversampled bit timing (OVS baud ticks per bit), registered serial output, idle high.
module uart_tx_cfg #(
  parameter int DBIT  = 8,
  parameter int OVS   = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  input  logic             tx_valid,
  input  logic [DBIT-1:0]  tx_din,
  output logic             tx_ready,
  output logic             tx_done_tick,
  output logic             busy,
  output logic             tx
);

  localparam int SW = $clog2(2 * OVS);
  localparam int BW = $clog2(DBIT + 1);
  localparam logic [SW-1:0] LAST_1   = SW'(OVS - 1);
  localparam logic [SW-1:0] LAST_2   = SW'(2 * OVS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DBIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_tick_cnt;
  logic [SW-1:0]    r_s_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic [DBIT-1:0]  r_shreg;
  logic             r_par;
  logic             r_par_en;
  logic             r_stop2;
  logic             r_tx;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic [DIV_W-1:0] w_div_m1;
  logic [SW-1:0]    w_last;
  logic             w_tick;
  logic             w_bit_end;

  // A divisor of 0 behaves as 1, i.e. a tick every clock.
  assign w_div_m1  = (r_div == '0) ? '0 : (r_div - DIV_W'(1));
  assign w_tick    = (r_state != S_IDLE) && (r_tick_cnt == w_div_m1);
  assign w_last    = ((r_state == S_STOP) && r_stop2) ? LAST_2 : LAST_1;
  assign w_bit_end = w_tick && (r_s_cnt == w_last);

  assign tx           = r_tx;
  assign tx_ready     = r_ready;
  assign busy         = r_busy;
  assign tx_done_tick = r_done;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
    end else if ((r_state == S_IDLE) || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s_cnt <= '0;
    end else if ((r_state == S_IDLE) || w_bit_end) begin
      r_s_cnt <= '0;
    end else if (w_tick) begin
      r_s_cnt <= r_s_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_par     <= 1'b0;
      r_par_en  <= 1'b0;
      r_stop2   <= 1'b0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            r_div     <= baud_div;
            r_shreg   <= tx_din;
            // mode 01 -> even, 10 -> odd; 00/11 disable parity
            r_par     <= (^tx_din) ^ parity_mode[1];
            r_par_en  <= parity_mode[1] ^ parity_mode[0];
            r_stop2   <= stop2;
            r_bit_cnt <= '0;
            r_tx      <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_tx    <= r_shreg[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_shreg <= r_shreg >> 1;
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              if (r_par_en) begin
                r_tx    <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
              r_tx      <= r_shreg[1];
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
